// File: rtl/tank_pkg.sv
// Shared tank game types: facing directions, keycodes, game-state encodings
// and the keycode-to-direction decoder used by the tank movement logic.
package tank_pkg;

  typedef logic [9:0] pos_t;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    MV_IDLE   = 2'd0,
    MV_CALC   = 2'd1,
    MV_CHECK  = 2'd2,
    MV_COMMIT = 2'd3
  } mvState_t;

  localparam logic [7:0] KEY_NONE = 8'h00;
  localparam logic [7:0] KEY_W    = 8'h1A;
  localparam logic [7:0] KEY_A    = 8'h04;
  localparam logic [7:0] KEY_S    = 8'h16;
  localparam logic [7:0] KEY_D    = 8'h07;
  localparam logic [7:0] KEY_Q    = 8'h14;
  localparam logic [7:0] KEY_E    = 8'h08;

  localparam logic [1:0] STATE_MENU = 2'd0;
  localparam logic [1:0] STATE_PLAY = 2'd1;
  localparam logic [1:0] STATE_OVER = 2'd2;

  typedef struct packed {
    logic valid;
    dir_t dir;
  } keyMove_t;

  // Only W/A/S/D are movement keys; Q/E belong to the tank selector.
  function automatic keyMove_t decodeKey(input logic [7:0] key);
    keyMove_t m;
    m.valid = 1'b1;
    m.dir   = DIR_UP;
    case (key)
      KEY_W:   m.dir = DIR_UP;
      KEY_D:   m.dir = DIR_RIGHT;
      KEY_S:   m.dir = DIR_DOWN;
      KEY_A:   m.dir = DIR_LEFT;
      default: begin
        m.valid = 1'b0;
        m.dir   = DIR_UP;
      end
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tank_mover_if.sv
// Bus between the game top level and the tank mover: control inputs in,
// tank positions/facings and busy out.
interface tank_mover_if;
  import tank_pkg::*;

  logic [7:0] keycode;
  logic [1:0] currentState;
  logic [1:0] currentTank;
  pos_t       tank0X;
  pos_t       tank0Y;
  pos_t       tank1X;
  pos_t       tank1Y;
  dir_t       tank0Dir;
  dir_t       tank1Dir;
  logic       busy;

  modport master (
    output keycode, currentState, currentTank,
    input  tank0X, tank0Y, tank1X, tank1Y, tank0Dir, tank1Dir, busy
  );

  modport slave (
    input  keycode, currentState, currentTank,
    output tank0X, tank0Y, tank1X, tank1Y, tank0Dir, tank1Dir, busy
  );

endinterface

// File: rtl/frame_tick_detect.sv
// Two-flop rising-edge detector for the VGA frame pulse; tick is high for
// exactly one Clk cycle per frame.
module frame_tick_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic tick
);

  logic frameMeta;
  logic frameLast;

  // Sample the frame pulse and keep its previous value for edge detection.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frameMeta <= 1'b0;
      frameLast <= 1'b0;
    end else begin
      frameMeta <= frame_clk;
      frameLast <= frameMeta;
    end
  end

  assign tick = frameMeta & ~frameLast;

endmodule

// File: rtl/tank_mover.sv
// Moves the selected tank one STEP per frame from W/A/S/D, clamped to the
// arena and refused when it would overlap the other tank.
module tank_mover
  import tank_pkg::*;
#(
  parameter int         STEP       = 2,
  parameter int         TANK_SIZE  = 32,
  parameter int         ARENA_XMAX = 639,
  parameter int         ARENA_YMAX = 479,
  parameter int         T0_X0      = 64,
  parameter int         T0_Y0      = 224,
  parameter int         T1_X0      = 544,
  parameter int         T1_Y0      = 224,
  parameter logic [1:0] PLAY_STATE = STATE_PLAY
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         frame_clk,
  tank_mover_if.slave  bus
);

  localparam pos_t             X_LIM  = pos_t'(ARENA_XMAX + 1 - TANK_SIZE);
  localparam pos_t             Y_LIM  = pos_t'(ARENA_YMAX + 1 - TANK_SIZE);
  localparam pos_t             SIZE_P = pos_t'(TANK_SIZE);
  localparam logic signed [10:0] STEP_S = 11'(STEP);

  function automatic pos_t clampAxis(input logic signed [10:0] v, input pos_t hi);
    pos_t r;
    if (v < 11'sd0) begin
      r = 10'd0;
    end else if (v > $signed({1'b0, hi})) begin
      r = hi;
    end else begin
      r = v[9:0];
    end
    return r;
  endfunction

  function automatic pos_t absDiff(input pos_t a, input pos_t b);
    pos_t r;
    if (a > b) begin
      r = a - b;
    end else begin
      r = b - a;
    end
    return r;
  endfunction

  logic              tick;
  mvState_t          stateR, stateNext;
  logic              busyR;
  logic              idxR;
  dir_t              dirR;
  logic signed [10:0] candXR, candYR, candXNext, candYNext;
  pos_t              tank0XR, tank0YR, tank1XR, tank1YR;
  dir_t              tank0DirR, tank1DirR;
  pos_t              curX, curY, otherX, otherY, clampX, clampY;
  logic              blocked;
  logic              startMove;
  keyMove_t          keyMove;

  wire unusedOk = &{1'b1, bus.currentTank[1]};

  frame_tick_detect uTick (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  assign keyMove   = decodeKey(bus.keycode);
  assign startMove = tick && (bus.currentState == PLAY_STATE) && keyMove.valid;

  // Next-state logic: one cycle per state once a move is accepted.
  always_comb begin
    stateNext = stateR;
    case (stateR)
      MV_IDLE: begin
        if (startMove) begin
          stateNext = MV_CALC;
        end else begin
          stateNext = MV_IDLE;
        end
      end
      MV_CALC:   stateNext = MV_CHECK;
      MV_CHECK:  stateNext = MV_COMMIT;
      MV_COMMIT: stateNext = MV_IDLE;
      default:   stateNext = MV_IDLE;
    endcase
  end

  // Candidate position, arena clamp and overlap test against the other tank.
  always_comb begin
    curX   = tank0XR;
    curY   = tank0YR;
    otherX = tank1XR;
    otherY = tank1YR;
    if (idxR) begin
      curX   = tank1XR;
      curY   = tank1YR;
      otherX = tank0XR;
      otherY = tank0YR;
    end else begin
      curX   = tank0XR;
      curY   = tank0YR;
      otherX = tank1XR;
      otherY = tank1YR;
    end
    candXNext = $signed({1'b0, curX});
    candYNext = $signed({1'b0, curY});
    case (dirR)
      DIR_UP:    candYNext = $signed({1'b0, curY}) - STEP_S;
      DIR_RIGHT: candXNext = $signed({1'b0, curX}) + STEP_S;
      DIR_DOWN:  candYNext = $signed({1'b0, curY}) + STEP_S;
      DIR_LEFT:  candXNext = $signed({1'b0, curX}) - STEP_S;
      default: begin
        candXNext = $signed({1'b0, curX});
        candYNext = $signed({1'b0, curY});
      end
    endcase
    clampX  = clampAxis(candXR, X_LIM);
    clampY  = clampAxis(candYR, Y_LIM);
    blocked = (absDiff(clampX, otherX) < SIZE_P) && (absDiff(clampY, otherY) < SIZE_P);
  end

  // State, latched request, candidate and tank registers. The commit lands on
  // the edge into COMMIT so the new values are visible throughout COMMIT.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stateR    <= MV_IDLE;
      busyR     <= 1'b0;
      idxR      <= 1'b0;
      dirR      <= DIR_UP;
      candXR    <= 11'sd0;
      candYR    <= 11'sd0;
      tank0XR   <= pos_t'(T0_X0);
      tank0YR   <= pos_t'(T0_Y0);
      tank1XR   <= pos_t'(T1_X0);
      tank1YR   <= pos_t'(T1_Y0);
      tank0DirR <= DIR_RIGHT;
      tank1DirR <= DIR_LEFT;
    end else begin
      stateR <= stateNext;
      busyR  <= (stateNext != MV_IDLE);
      if ((stateR == MV_IDLE) && startMove) begin
        idxR <= bus.currentTank[0];
        dirR <= keyMove.dir;
      end
      if (stateR == MV_CALC) begin
        candXR <= candXNext;
        candYR <= candYNext;
      end
      if (stateNext == MV_COMMIT) begin
        if (idxR) begin
          tank1DirR <= dirR;
          if (!blocked) begin
            tank1XR <= clampX;
            tank1YR <= clampY;
          end
        end else begin
          tank0DirR <= dirR;
          if (!blocked) begin
            tank0XR <= clampX;
            tank0YR <= clampY;
          end
        end
      end
    end
  end

  assign bus.tank0X   = tank0XR;
  assign bus.tank0Y   = tank0YR;
  assign bus.tank1X   = tank1XR;
  assign bus.tank1Y   = tank1YR;
  assign bus.tank0Dir = tank0DirR;
  assign bus.tank1Dir = tank1DirR;
  assign bus.busy     = busyR;

endmodule

// File: tb/tb_tank_mover.sv
// Scoreboard bench for tank_mover: frames queue expected before/after tank
// snapshots; a monitor checks them against the busy window of each move.
module tb_tank_mover;

  localparam logic [7:0] K_W = 8'h1A;
  localparam logic [7:0] K_A = 8'h04;
  localparam logic [7:0] K_S = 8'h16;
  localparam logic [7:0] K_D = 8'h07;
  localparam logic [7:0] K_Q = 8'h14;
  localparam logic [7:0] K_E = 8'h08;
  localparam logic [1:0] PLAY = 2'd1;

  typedef struct {
    int x0; int y0; int d0;
    int x1; int y1; int d1;
  } snap_t;

  typedef struct {
    snap_t prev;
    snap_t exp;
    int    len;
  } expItem_t;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic frameClk = 1'b0;

  tank_mover_if bus ();

  tank_mover dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frameClk),
    .bus       (bus)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;
  expItem_t sbq[$];
  snap_t model;
  snap_t resetSnap = '{x0: 64, y0: 224, d0: 1, x1: 544, y1: 224, d1: 3};

  function automatic snap_t readDut();
    snap_t s;
    s.x0 = int'(bus.tank0X);  s.y0 = int'(bus.tank0Y);  s.d0 = int'(bus.tank0Dir);
    s.x1 = int'(bus.tank1X);  s.y1 = int'(bus.tank1Y);  s.d1 = int'(bus.tank1Dir);
    return s;
  endfunction

  function automatic bit snapEq(snap_t a, snap_t b);
    return (a.x0 == b.x0) && (a.y0 == b.y0) && (a.d0 == b.d0) &&
           (a.x1 == b.x1) && (a.y1 == b.y1) && (a.d1 == b.d1);
  endfunction

  task automatic chk(input bit ok, input string name, input snap_t act, input snap_t exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got t0(%0d,%0d,d%0d) t1(%0d,%0d,d%0d) expected t0(%0d,%0d,d%0d) t1(%0d,%0d,d%0d)",
               name, act.x0, act.y0, act.d0, act.x1, act.y1, act.d1,
               exp.x0, exp.y0, exp.d0, exp.x1, exp.y1, exp.d1);
    end
  endtask

  task automatic chkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference move: step, clamp to [0,608]x[0,448], refuse on overlap.
  function automatic snap_t applyMove(snap_t s, bit idx, logic [7:0] key);
    int cx, cy, ox, oy, d, dx, dy;
    snap_t r = s;
    cx = idx ? s.x1 : s.x0;  cy = idx ? s.y1 : s.y0;
    ox = idx ? s.x0 : s.x1;  oy = idx ? s.y0 : s.y1;
    d = 0;
    if (key == K_W) begin cy -= 2; d = 0; end
    else if (key == K_D) begin cx += 2; d = 1; end
    else if (key == K_S) begin cy += 2; d = 2; end
    else begin cx -= 2; d = 3; end
    if (cx < 0) cx = 0;
    if (cx > 608) cx = 608;
    if (cy < 0) cy = 0;
    if (cy > 448) cy = 448;
    dx = (cx > ox) ? cx - ox : ox - cx;
    dy = (cy > oy) ? cy - oy : oy - cy;
    if (idx) begin
      r.d1 = d;
      if (!(dx < 32 && dy < 32)) begin r.x1 = cx; r.y1 = cy; end
    end else begin
      r.d0 = d;
      if (!(dx < 32 && dy < 32)) begin r.x0 = cx; r.y0 = cy; end
    end
    return r;
  endfunction

  function automatic bit isMove(logic [7:0] key, logic [1:0] st);
    return (st == PLAY) && ((key == K_W) || (key == K_A) || (key == K_S) || (key == K_D));
  endfunction

  task automatic doReset();
    Reset = 1'b1;
    frameClk = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    model = resetSnap;
  endtask

  task automatic pushMove(input logic [7:0] key, input logic [1:0] st, input bit tk);
    expItem_t it;
    if (isMove(key, st)) begin
      it.prev = model;
      model   = applyMove(model, tk, key);
      it.exp  = model;
      it.len  = 3;
      sbq.push_back(it);
    end
  endtask

  task automatic frame(input logic [7:0] key, input logic [1:0] st, input bit tk);
    bus.keycode = key;
    bus.currentState = st;
    bus.currentTank = {1'b0, tk};
    pushMove(key, st, tk);
    frameClk = 1'b1;
    repeat (2) @(negedge Clk);
    frameClk = 1'b0;
    repeat (6) @(negedge Clk);
  endtask

  task automatic waitBusy();
    for (int i = 0; i < 10 && !bus.busy; i++) @(negedge Clk);
  endtask

  // Monitor: hold old values during CALC/CHECK, new ones from the third busy cycle.
  int busyCnt = 0;
  bit haveCur = 1'b0;
  expItem_t cur;
  always @(negedge Clk) begin
    snap_t s;
    s = readDut();
    if (bus.busy) begin
      busyCnt++;
      if (busyCnt == 1) begin
        if (sbq.size() == 0) begin
          haveCur = 1'b0;
          chkVal("unexpected move", 1, 0);
        end else begin
          cur = sbq.pop_front();
          haveCur = 1'b1;
        end
      end
      if (haveCur) begin
        if (busyCnt < 3) chk(snapEq(s, cur.prev), "hold before commit", s, cur.prev);
        else if (busyCnt == 3) chk(snapEq(s, cur.exp), "commit visible", s, cur.exp);
      end
    end else if (busyCnt != 0) begin
      if (haveCur) begin
        chkVal("busy length", busyCnt, cur.len);
        chk(snapEq(s, cur.exp), "after move", s, cur.exp);
      end
      busyCnt = 0;
      haveCur = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    expItem_t it;
    bus.keycode = 8'h00;
    bus.currentState = 2'd0;
    bus.currentTank = 2'd0;
    @(negedge Clk);
    doReset();
    chk(snapEq(readDut(), resetSnap), "reset state", readDut(), resetSnap);
    chkVal("reset busy", int'(bus.busy), 0);

    frame(K_D, PLAY, 1'b0);
    chkVal("one step right x", int'(bus.tank0X), 66);
    chkVal("one step tank1 x", int'(bus.tank1X), 544);

    repeat (229) frame(K_D, PLAY, 1'b0);
    chkVal("blocked x", int'(bus.tank0X), 512);
    chkVal("blocked dir", int'(bus.tank0Dir), 1);
    chkVal("blocked tank1 x", int'(bus.tank1X), 544);
    chkVal("blocked tank1 dir", int'(bus.tank1Dir), 3);

    doReset();
    repeat (120) frame(K_W, PLAY, 1'b0);
    chkVal("top clamp y", int'(bus.tank0Y), 0);
    chkVal("top clamp dir", int'(bus.tank0Dir), 0);
    chkVal("top clamp x", int'(bus.tank0X), 64);

    repeat (35) frame(K_A, PLAY, 1'b0);
    chkVal("left clamp x", int'(bus.tank0X), 0);
    chkVal("left clamp dir", int'(bus.tank0Dir), 3);

    repeat (40) frame(K_D, PLAY, 1'b1);
    chkVal("right clamp x", int'(bus.tank1X), 608);
    repeat (120) frame(K_S, PLAY, 1'b1);
    chkVal("bottom clamp y", int'(bus.tank1Y), 448);
    chkVal("bottom clamp dir", int'(bus.tank1Dir), 2);

    repeat (4) frame(K_D, 2'd0, 1'b0);
    repeat (3) frame(K_Q, PLAY, 1'b0);
    frame(K_E, PLAY, 1'b1);
    frame(8'h00, PLAY, 1'b0);
    frame(K_W, 2'd2, 1'b1);
    chk(snapEq(readDut(), model), "ignored frames", readDut(), model);

    // Inputs changed mid-flight must not alter the latched move.
    bus.keycode = K_W;
    bus.currentState = PLAY;
    bus.currentTank = 2'd1;
    pushMove(K_W, PLAY, 1'b1);
    frameClk = 1'b1;
    waitBusy();
    bus.keycode = K_A;
    bus.currentTank = 2'd0;
    bus.currentState = 2'd0;
    frameClk = 1'b0;
    repeat (6) @(negedge Clk);
    chkVal("latched y", int'(bus.tank1Y), 446);

    // Reset during CHECK abandons the move.
    bus.keycode = K_S;
    bus.currentState = PLAY;
    bus.currentTank = 2'd0;
    it.prev = model;
    it.exp  = resetSnap;
    it.len  = 2;
    sbq.push_back(it);
    frameClk = 1'b1;
    waitBusy();
    frameClk = 1'b0;
    bus.keycode = 8'h00;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    model = resetSnap;
    chk(snapEq(readDut(), resetSnap), "abort reset values", readDut(), resetSnap);
    chkVal("abort busy", int'(bus.busy), 0);
    repeat (4) @(negedge Clk);

    frame(K_D, PLAY, 1'b0);
    chkVal("after abort x", int'(bus.tank0X), 66);

    repeat (5) @(negedge Clk);
    chkVal("scoreboard drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
